// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline boundary: registers MEM results into WB and selects the write-back value.
// Turns memory readiness into a pipeline freeze and keeps saturating stall/memory-op counters.
module mem_wb_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic              mem_wb_en,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              mem_ready,
  input  logic              flush,
  output logic              freeze,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_dest,
  output logic [DATA_W-1:0] wb_value,
  output logic              fwd_valid,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  mem_op_cnt
);

  typedef enum logic {StIdle, StWait} state_e;

  state_e              state_q, state_d;
  logic                wb_en_q, wb_en_d;
  logic [REG_AW-1:0]   wb_dest_q, wb_dest_d;
  logic [DATA_W-1:0]   wb_value_q, wb_value_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]    mem_op_cnt_q, mem_op_cnt_d;
  logic                mem_req;

  // Once an access is in flight MEM is frozen, so flush only matters in idle.
  assign mem_req = (mem_r_en | mem_w_en) & ((state_q == StWait) | ~flush);
  assign freeze  = ~rst & mem_req & ~mem_ready;

  always_comb begin
    state_d      = state_q;
    wb_en_d      = wb_en_q;
    wb_dest_d    = wb_dest_q;
    wb_value_d   = wb_value_q;
    stall_cnt_d  = stall_cnt_q;
    mem_op_cnt_d = mem_op_cnt_q;

    if (freeze) begin
      state_d = StWait;
      wb_en_d = 1'b0;
      if (stall_cnt_q != {CNT_W{1'b1}}) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end else begin
      state_d    = StIdle;
      wb_dest_d  = mem_dest;
      wb_value_d = mem_r_en ? mem_result : alu_res;
      if (mem_req) begin
        wb_en_d = mem_wb_en;
        if (mem_op_cnt_q != {CNT_W{1'b1}}) begin
          mem_op_cnt_d = mem_op_cnt_q + 1'b1;
        end
      end else begin
        wb_en_d = mem_wb_en & ~flush;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      wb_en_q      <= 1'b0;
      wb_dest_q    <= '0;
      wb_value_q   <= '0;
      stall_cnt_q  <= '0;
      mem_op_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      wb_en_q      <= wb_en_d;
      wb_dest_q    <= wb_dest_d;
      wb_value_q   <= wb_value_d;
      stall_cnt_q  <= stall_cnt_d;
      mem_op_cnt_q <= mem_op_cnt_d;
    end
  end

  assign wb_en      = wb_en_q;
  assign fwd_valid  = wb_en_q;
  assign wb_dest    = wb_dest_q;
  assign wb_value   = wb_value_q;
  assign stall_cnt  = stall_cnt_q;
  assign mem_op_cnt = mem_op_cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized traffic
// checked against a transaction-level model of the write-back stage.
module tb_mem_wb_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_r_en, mem_w_en, mem_wb_en, mem_ready, flush;
  logic [AW-1:0] mem_dest;
  logic [DW-1:0] alu_res, mem_result;
  logic          freeze, wb_en, fwd_valid;
  logic [AW-1:0] wb_dest;
  logic [DW-1:0] wb_value;
  logic [CW-1:0] stall_cnt, mem_op_cnt;

  int total = 0;
  int bad   = 0;

  // Model state: is an access outstanding, and what WB should show.
  logic          m_pending;
  logic          m_wb_en;
  logic [AW-1:0] m_dest;
  logic [DW-1:0] m_val;
  logic [CW-1:0] m_stall, m_ops;
  logic          exp_freeze, obs_freeze;

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_r_en   (mem_r_en),
    .mem_w_en   (mem_w_en),
    .mem_wb_en  (mem_wb_en),
    .mem_dest   (mem_dest),
    .alu_res    (alu_res),
    .mem_result (mem_result),
    .mem_ready  (mem_ready),
    .flush      (flush),
    .freeze     (freeze),
    .wb_en      (wb_en),
    .wb_dest    (wb_dest),
    .wb_value   (wb_value),
    .fwd_valid  (fwd_valid),
    .stall_cnt  (stall_cnt),
    .mem_op_cnt (mem_op_cnt)
  );

  task automatic drive(input logic r, input logic w, input logic wbe, input logic [AW-1:0] d,
                       input logic [DW-1:0] alu, input logic [DW-1:0] res, input logic rdy,
                       input logic fl);
    mem_r_en = r; mem_w_en = w; mem_wb_en = wbe; mem_dest = d;
    alu_res = alu; mem_result = res; mem_ready = rdy; flush = fl;
  endtask

  // Instruction-level view: a memory instruction either waits (bubble) or retires.
  task automatic model_step();
    logic is_mem, live;
    is_mem = mem_r_en | mem_w_en;
    live   = m_pending | ~flush;
    exp_freeze = 1'b0;
    if (rst) begin
      m_pending = 1'b0; m_wb_en = 1'b0; m_dest = '0; m_val = '0; m_stall = '0; m_ops = '0;
    end else if (is_mem && live && !mem_ready) begin
      exp_freeze = 1'b1;
      m_pending  = 1'b1;
      m_wb_en    = 1'b0;
      if (m_stall != 8'hFF) m_stall = m_stall + 8'd1;
    end else begin
      if (is_mem && live && m_ops != 8'hFF) m_ops = m_ops + 8'd1;
      m_wb_en   = mem_wb_en && live;
      m_dest    = mem_dest;
      m_val     = mem_r_en ? mem_result : alu_res;
      m_pending = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    obs_freeze = freeze;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (wb_en !== 1'b0 || wb_dest !== '0 || wb_value !== '0 || fwd_valid !== 1'b0 ||
        stall_cnt !== '0 || mem_op_cnt !== '0) begin
      bad++;
      $display("FAIL reset_state: got en=%b dest=%0h val=%0h fwd=%b st=%0d ops=%0d want all 0",
               wb_en, wb_dest, wb_value, fwd_valid, stall_cnt, mem_op_cnt);
    end
    drive(1'b1, 1'b0, 1'b1, 4'd3, 32'h10, 32'h55, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    total++;
    if (obs_freeze !== 1'b0) begin
      bad++; $display("FAIL freeze_in_reset: got %b want 0", obs_freeze);
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    total++;
    if (wb_en !== 1'b0 || stall_cnt !== '0 || mem_op_cnt !== '0) begin
      bad++;
      $display("FAIL reset_mid_wait: got en=%b st=%0d ops=%0d want 0 0 0",
               wb_en, stall_cnt, mem_op_cnt);
    end
    // Back in idle: a hit must complete immediately with no freeze.
    drive(1'b1, 1'b0, 1'b1, 4'd3, 32'h10, 32'h77, 1'b1, 1'b0);
    tick();
    total++;
    if (obs_freeze !== 1'b0 || wb_en !== 1'b1 || wb_value !== 32'h77 || mem_op_cnt !== 8'd1) begin
      bad++;
      $display("FAIL idle_after_reset: got fr=%b en=%b val=%0h ops=%0d want 0 1 77 1",
               obs_freeze, wb_en, wb_value, mem_op_cnt);
    end
  endtask

  task automatic test_alu();
    apply_reset();
    drive(1'b0, 1'b0, 1'b1, 4'd5, 32'h0000_1234, 32'h9999, 1'b0, 1'b0);
    tick();
    total++;
    if (obs_freeze !== 1'b0 || wb_en !== 1'b1 || fwd_valid !== 1'b1 || wb_dest !== 4'd5 ||
        wb_value !== 32'h1234) begin
      bad++;
      $display("FAIL alu_wb: got fr=%b en=%b fwd=%b dest=%0d val=%0h want 0 1 1 5 1234",
               obs_freeze, wb_en, fwd_valid, wb_dest, wb_value);
    end
  endtask

  task automatic test_load_miss();
    apply_reset();
    drive(1'b1, 1'b0, 1'b1, 4'd2, 32'h400, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (obs_freeze !== 1'b1 || wb_en !== 1'b0) begin
        bad++; $display("FAIL load_miss_bubble[%0d]: got fr=%b en=%b want 1 0", i, obs_freeze, wb_en);
      end
    end
    mem_ready = 1'b1; mem_result = 32'hDEAD_BEEF;
    tick();
    total++;
    if (obs_freeze !== 1'b0 || wb_en !== 1'b1 || wb_dest !== 4'd2 || wb_value !== 32'hDEAD_BEEF ||
        stall_cnt !== 8'd4 || mem_op_cnt !== 8'd1) begin
      bad++;
      $display("FAIL load_miss_done: got fr=%b en=%b dest=%0d val=%0h st=%0d ops=%0d want 0 1 2 deadbeef 4 1",
               obs_freeze, wb_en, wb_dest, wb_value, stall_cnt, mem_op_cnt);
    end
  endtask

  task automatic test_cache_hit();
    apply_reset();
    drive(1'b1, 1'b0, 1'b1, 4'd9, 32'h800, 32'hCAFE_F00D, 1'b1, 1'b0);
    tick();
    total++;
    if (obs_freeze !== 1'b0 || wb_en !== 1'b1 || wb_value !== 32'hCAFE_F00D ||
        stall_cnt !== 8'd0 || mem_op_cnt !== 8'd1) begin
      bad++;
      $display("FAIL cache_hit: got fr=%b en=%b val=%0h st=%0d ops=%0d want 0 1 cafef00d 0 1",
               obs_freeze, wb_en, wb_value, stall_cnt, mem_op_cnt);
    end
  endtask

  task automatic test_store();
    apply_reset();
    drive(1'b0, 1'b1, 1'b0, 4'd7, 32'h1000, 32'h1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (obs_freeze !== 1'b1 || wb_en !== 1'b0) begin
        bad++; $display("FAIL store_wait[%0d]: got fr=%b en=%b want 1 0", i, obs_freeze, wb_en);
      end
    end
    mem_ready = 1'b1;
    tick();
    total++;
    if (obs_freeze !== 1'b0 || wb_en !== 1'b0 || stall_cnt !== 8'd2 || mem_op_cnt !== 8'd1) begin
      bad++;
      $display("FAIL store_done: got fr=%b en=%b st=%0d ops=%0d want 0 0 2 1",
               obs_freeze, wb_en, stall_cnt, mem_op_cnt);
    end
    // Write-back addressing store writes the ALU result.
    drive(1'b0, 1'b1, 1'b1, 4'd6, 32'h2004, 32'h1, 1'b1, 1'b0);
    tick();
    total++;
    if (wb_en !== 1'b1 || wb_value !== 32'h2004 || mem_op_cnt !== 8'd2) begin
      bad++;
      $display("FAIL store_writeback: got en=%b val=%0h ops=%0d want 1 2004 2", wb_en, wb_value, mem_op_cnt);
    end
  endtask

  task automatic test_flush_saturation();
    apply_reset();
    drive(1'b1, 1'b0, 1'b1, 4'd4, 32'h40, 32'h44, 1'b0, 1'b1);
    tick();
    total++;
    if (obs_freeze !== 1'b0 || wb_en !== 1'b0 || stall_cnt !== 8'd0 || mem_op_cnt !== 8'd0) begin
      bad++;
      $display("FAIL flush_idle: got fr=%b en=%b st=%0d ops=%0d want 0 0 0 0",
               obs_freeze, wb_en, stall_cnt, mem_op_cnt);
    end
    // Flush arriving after the access is issued must be ignored.
    flush = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    total++;
    if (obs_freeze !== 1'b1) begin
      bad++; $display("FAIL flush_in_wait_freeze: got %b want 1", obs_freeze);
    end
    mem_ready = 1'b1;
    tick();
    total++;
    if (wb_en !== 1'b1 || wb_value !== 32'h44 || mem_op_cnt !== 8'd1) begin
      bad++;
      $display("FAIL flush_in_wait_done: got en=%b val=%0h ops=%0d want 1 44 1", wb_en, wb_value, mem_op_cnt);
    end
    // Drive the 8-bit stall counter past all-ones.
    drive(1'b1, 1'b0, 1'b1, 4'd1, 32'h0, 32'h5, 1'b0, 1'b0);
    for (int i = 0; i < 258; i++) tick();
    total++;
    if (stall_cnt !== 8'hFF) begin
      bad++; $display("FAIL stall_saturate: got %0h want ff", stall_cnt);
    end
    tick();
    tick();
    total++;
    if (stall_cnt !== 8'hFF || obs_freeze !== 1'b1) begin
      bad++; $display("FAIL stall_hold: got st=%0h fr=%b want ff 1", stall_cnt, obs_freeze);
    end
    mem_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      if (!m_pending) begin
        drive($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
              AW'($urandom), $urandom, $urandom, $urandom_range(0, 2) != 0,
              $urandom_range(0, 5) == 0);
      end else begin
        mem_ready  = $urandom_range(0, 2) == 0;
        mem_result = $urandom;
        flush      = $urandom_range(0, 3) == 0;
      end
      tick();
      total++;
      if (obs_freeze !== exp_freeze || wb_en !== m_wb_en || fwd_valid !== m_wb_en ||
          wb_dest !== m_dest || wb_value !== m_val || stall_cnt !== m_stall || mem_op_cnt !== m_ops) begin
        bad++;
        $display("FAIL random[%0d]: got fr=%b en=%b fwd=%b d=%0h v=%0h st=%0d ops=%0d want fr=%b en=%b d=%0h v=%0h st=%0d ops=%0d",
                 i, obs_freeze, wb_en, fwd_valid, wb_dest, wb_value, stall_cnt, mem_op_cnt,
                 exp_freeze, m_wb_en, m_dest, m_val, m_stall, m_ops);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    test_reset();
    test_alu();
    test_load_miss();
    test_cache_hit();
    test_store();
    test_flush_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
